// File: rtl/cv32e40p_prefetch_buffer_if.sv
// ---- cv32e40p_prefetch_buffer_if : fetch-side and memory-side bundle of the prefetcher (rev 1.0) ----
// Signal suffixes are from the prefetcher's point of view; slave = prefetcher, master = core/memory side.
`default_nettype none

interface cv32e40p_prefetch_buffer_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  modport slave (
    input  req_i, branch_i, branch_addr_i, fetch_ready_i,
           instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fetch_valid_o, fetch_rdata_o, fetch_addr_o,
           instr_req_o, instr_addr_o, busy_o
  );

  modport master (
    output req_i, branch_i, branch_addr_i, fetch_ready_i,
           instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fetch_valid_o, fetch_rdata_o, fetch_addr_o,
           instr_req_o, instr_addr_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/cv32e40p_prefetch_buffer.sv
// ---- cv32e40p_prefetch_buffer : OBI instruction prefetcher with credit-limited flushable FIFO (rev 1.0) ----
`default_nettype none

module cv32e40p_prefetch_buffer #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  cv32e40p_prefetch_buffer_if.slave     bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_MAX_OUT  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW:0]   C_DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            started_q, started_d;
  logic            stale_q, stale_d;
  logic [31:0]     next_addr_q, next_addr_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     mem_q [DEPTH];

  logic            fifo_valid;
  logic            pop;
  logic            drop;
  logic            push;
  logic            issue;
  logic            accept;
  logic            instr_req;
  logic [31:0]     instr_addr;
  logic [CW:0]     credit;
  logic [31:0]     target;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus.branch_addr_i[1:0];
  assign target     = {bus.branch_addr_i[31:2], 2'b00};
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & bus.fetch_ready_i & ~bus.branch_i;
  assign drop       = bus.instr_rvalid_i & (discard_q != '0);
  assign push       = bus.instr_rvalid_i & ~drop & ~bus.branch_i;

  // A same-cycle pop frees its slot, which lets a DEPTH=2 buffer sustain one instruction per cycle.
  assign credit = {1'b0, outstanding_q} + {1'b0, count_q} - (CW+1)'(pop);
  assign issue  = started_q & bus.req_i & ~bus.branch_i &
                  (outstanding_q < C_MAX_OUT) & (credit < C_DEPTH_W);

  always_comb begin
    state_d       = state_q;
    started_d     = started_q;
    stale_d       = stale_q;
    next_addr_d   = next_addr_q;
    req_addr_d    = req_addr_q;
    fetch_addr_d  = fetch_addr_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    instr_req     = 1'b0;
    instr_addr    = next_addr_q;

    case (state_q)
      IDLE: begin
        instr_req = issue;
        if (issue) begin
          next_addr_d = next_addr_q + 32'd4;
          if (!bus.instr_gnt_i) begin
            state_d    = WAIT_GNT;
            req_addr_d = next_addr_q;
          end
        end
      end
      WAIT_GNT: begin
        instr_req  = 1'b1;
        instr_addr = req_addr_q;
        if (bus.instr_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept        = instr_req & bus.instr_gnt_i;
    outstanding_d = outstanding_q + CW'(accept) - CW'(bus.instr_rvalid_i);
    // A grant for a request that was pending across a branch returns old-stream data.
    discard_d     = discard_q - CW'(drop) + CW'(accept & stale_q);
    if (accept) stale_d = 1'b0;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d     = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (bus.branch_i) begin
      started_d    = 1'b1;
      next_addr_d  = target;
      fetch_addr_d = target;
      discard_d    = outstanding_d;
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      if ((state_q == WAIT_GNT) && !bus.instr_gnt_i) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      started_q     <= 1'b0;
      stale_q       <= 1'b0;
      next_addr_q   <= '0;
      req_addr_q    <= '0;
      fetch_addr_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      stale_q       <= stale_d;
      next_addr_q   <= next_addr_d;
      req_addr_q    <= req_addr_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) mem_q[wr_ptr_q] <= bus.instr_rdata_i;
    end
  end

  assign bus.fetch_valid_o = fifo_valid;
  assign bus.fetch_rdata_o = mem_q[rd_ptr_q];
  assign bus.fetch_addr_o  = fetch_addr_q;
  assign bus.instr_req_o   = instr_req;
  assign bus.instr_addr_o  = instr_addr;
  assign bus.busy_o        = (outstanding_q != '0) | instr_req;

`ifndef SYNTHESIS
  a_no_overflow:    assert property (@(posedge clk) disable iff (rst) !(push && (count_q == C_DEPTH)));
  a_rvalid_legal:   assert property (@(posedge clk) disable iff (rst) !(bus.instr_rvalid_i && (outstanding_q == '0)));
  a_outstanding_ok: assert property (@(posedge clk) disable iff (rst) outstanding_q <= C_MAX_OUT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_prefetch_buffer.sv
// ---- tb_cv32e40p_prefetch_buffer : directed self-checking bench with a 1-cycle-latency memory model (rev 1.0) ----
`default_nettype none

module tb_cv32e40p_prefetch_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e40p_prefetch_buffer_if bus ();

  cv32e40p_prefetch_buffer #(.DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] rsp_q [$];
  logic        rv_hold = 1'b0;
  logic        cyc_req, cyc_acc;
  logic [31:0] cyc_addr;
  int          n_acc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: present the memory response, sample the request mid-cycle, advance past the edge.
  task automatic tick();
    if (!rv_hold && rsp_q.size() != 0) begin
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = mdata(rsp_q.pop_front());
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = '0;
    end
    #1;
    cyc_req  = bus.instr_req_o;
    cyc_addr = bus.instr_addr_o;
    cyc_acc  = bus.instr_req_o & bus.instr_gnt_i;
    if (cyc_acc) rsp_q.push_back(bus.instr_addr_o);
    @(posedge clk);
    #1;
    bus.branch_i       = 1'b0;
    bus.instr_rvalid_i = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] a);
    bus.branch_i      = 1'b1;
    bus.branch_addr_i = a;
    tick();
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_i         = 1'b0;
    bus.branch_i      = 1'b0;
    bus.branch_addr_i = '0;
    bus.fetch_ready_i = 1'b0;
    bus.instr_gnt_i   = 1'b0;
    bus.instr_rvalid_i= 1'b0;
    bus.instr_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_req",   bus.instr_req_o,   0);
    chk("rst_instr_addr",  bus.instr_addr_o,  0);
    chk("rst_fetch_valid", bus.fetch_valid_o, 0);
    chk("rst_fetch_rdata", bus.fetch_rdata_o, 0);
    chk("rst_fetch_addr",  bus.fetch_addr_o,  0);
    chk("rst_busy",        bus.busy_o,        0);
    rst = 1'b0;

    // Nothing is fetched before the boot redirect.
    bus.req_i = 1'b1; bus.instr_gnt_i = 1'b1; bus.fetch_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_req_before_boot", cyc_req, 0);
    end

    // Streaming from 0x80, one instruction per cycle once primed.
    branch_to(32'h0000_0083);
    chk("boot_fetch_addr",  bus.fetch_addr_o,  32'h80);
    chk("boot_valid_low",   bus.fetch_valid_o, 0);
    tick();
    chk("stream_req0",      cyc_addr, 32'h80);
    chk("stream_nolat",     bus.fetch_valid_o, 0);
    tick();
    chk("stream_req1",      cyc_addr, 32'h84);
    chk("stream_valid0",    bus.fetch_valid_o, 1);
    chk("stream_addr0",     bus.fetch_addr_o,  32'h80);
    chk("stream_data0",     bus.fetch_rdata_o, mdata(32'h80));
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("stream_req",     cyc_addr, 32'h84 + 32'(4 * i));
      chk("stream_valid",   bus.fetch_valid_o, 1);
      chk("stream_addr",    bus.fetch_addr_o,  32'h80 + 32'(4 * i));
      chk("stream_data",    bus.fetch_rdata_o, mdata(32'h80 + 32'(4 * i)));
    end

    // Stalled IF stage: DEPTH=2 credits allow exactly two requests.
    bus.fetch_ready_i = 1'b0;
    branch_to(32'h800);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cyc_acc) n_acc++;
    end
    chk("credit_req_count", n_acc, 2);
    chk("credit_req_low",   cyc_req, 0);
    chk("credit_head_addr", bus.fetch_addr_o, 32'h800);
    bus.fetch_ready_i = 1'b1;
    tick();
    chk("credit_pop_req",   cyc_req, 1);
    chk("credit_pop_addr",  cyc_addr, 32'h808);
    chk("credit_next_head", bus.fetch_addr_o, 32'h804);

    // Grant withheld: request and address held stable.
    branch_to(32'h80);
    tick();
    bus.instr_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req",  cyc_req, 1);
      chk("stall_addr", cyc_addr, 32'h84);
    end
    chk("stall_busy", bus.busy_o, 1);
    bus.instr_gnt_i = 1'b1;
    tick();
    chk("stall_accept", cyc_acc, 1);
    tick();
    chk("stall_next_addr", cyc_addr, 32'h88);

    // Two requests in flight at branch time: both returns dropped.
    branch_to(32'h100);
    rv_hold = 1'b1;
    tick();
    chk("flight_req0", cyc_addr, 32'h100);
    tick();
    chk("flight_req1", cyc_addr, 32'h104);
    tick();
    chk("flight_max_out", cyc_req, 0);
    rv_hold = 1'b0;
    branch_to(32'h200);
    chk("flight_branch_noreq", cyc_req, 0);
    chk("flight_valid_low0",   bus.fetch_valid_o, 0);
    chk("flight_fetch_addr",   bus.fetch_addr_o, 32'h200);
    chk("flight_busy",         bus.busy_o, 1);
    tick();
    chk("flight_new_req",      cyc_addr, 32'h200);
    chk("flight_valid_low1",   bus.fetch_valid_o, 0);
    tick();
    chk("flight_valid",        bus.fetch_valid_o, 1);
    chk("flight_addr",         bus.fetch_addr_o, 32'h200);
    chk("flight_data",         bus.fetch_rdata_o, mdata(32'h200));

    // Branch while a request waits for grant: its word is discarded.
    bus.instr_gnt_i = 1'b0;
    branch_to(32'h10);
    tick();
    chk("wg_req_addr", cyc_addr, 32'h10);
    branch_to(32'h40);
    chk("wg_not_retracted", cyc_req, 1);
    chk("wg_addr_held",     cyc_addr, 32'h10);
    tick();
    tick();
    chk("wg_addr_held2",    cyc_addr, 32'h10);
    bus.instr_gnt_i = 1'b1;
    tick();
    chk("wg_late_accept",   cyc_acc, 1);
    chk("wg_fetch_addr",    bus.fetch_addr_o, 32'h40);
    tick();
    chk("wg_new_req",       cyc_addr, 32'h40);
    chk("wg_no_stale",      bus.fetch_valid_o, 0);
    tick();
    chk("wg_valid",         bus.fetch_valid_o, 1);
    chk("wg_addr",          bus.fetch_addr_o, 32'h40);
    chk("wg_data",          bus.fetch_rdata_o, mdata(32'h40));

    // Branch, return and pop in one cycle with fetching disabled.
    bus.req_i = 1'b0;
    branch_to(32'h400);
    chk("tri_noreq",   cyc_req, 0);
    chk("tri_empty",   bus.fetch_valid_o, 0);
    chk("tri_busy",    bus.busy_o, 0);
    chk("tri_addr",    bus.fetch_addr_o, 32'h400);
    tick();
    chk("tri_idle_noreq", cyc_req, 0);
    chk("tri_idle_valid", bus.fetch_valid_o, 0);
    bus.req_i = 1'b1;
    tick();
    chk("tri_resume_req", cyc_addr, 32'h400);
    tick();
    chk("tri_resume_valid", bus.fetch_valid_o, 1);
    chk("tri_resume_data",  bus.fetch_rdata_o, mdata(32'h400));

    // Address wrap at the top of memory.
    branch_to(32'hFFFF_FFF8);
    tick();
    tick();
    chk("wrap_head0", bus.fetch_addr_o, 32'hFFFF_FFF8);
    tick();
    chk("wrap_req",   cyc_addr, 32'h0);
    chk("wrap_head1", bus.fetch_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_head2", bus.fetch_addr_o, 32'h0);
    chk("wrap_data2", bus.fetch_rdata_o, mdata(32'h0));

    // Asynchronous reset in mid-cycle clears everything at once.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_instr_req",   bus.instr_req_o,   0);
    chk("arst_fetch_valid", bus.fetch_valid_o, 0);
    chk("arst_fetch_addr",  bus.fetch_addr_o,  0);
    chk("arst_busy",        bus.busy_o,        0);
    rsp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
